// File: rtl/seg7_pkg.sv
// Shared constants and types for the two-digit 7-segment scan driver.
// Segment patterns are active-high, bit6..bit0 = a..g.
package seg7_pkg;

  localparam logic [6:0] SEG_ZERO = 7'b1111110;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;

  typedef enum logic [1:0] {
    PH_BLANK,
    PH_ON,
    PH_OFF
  } phase_t;

  typedef logic digit_t;

endpackage

// File: rtl/seg7_slot_timer.sv
// Slot counter, digit select and per-slot BLANK/ON/OFF phase FSM.
// Phase is valid in the same cycle as its slot_cnt; ON length is fixed per slot from i_dim.
module seg7_slot_timer
  import seg7_pkg::*;
#(
  parameter int DIV   = 50000,
  parameter int BLANK = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] i_dim,
  output phase_t     o_phase,
  output digit_t     o_sel,
  output logic       o_boundary,
  output logic       o_slot_start
);

  localparam int CW      = $clog2(DIV);
  localparam int ON_UNIT = (DIV - BLANK) / 8;

  logic [CW-1:0] r_slot_cnt;
  logic [CW-1:0] r_on_len;
  digit_t        r_sel;
  phase_t        r_phase;
  phase_t        w_phase_nxt;
  logic          w_slot_end;
  logic          w_slot_start;
  logic [CW-1:0] w_on_len_nxt;
  logic [CW-1:0] w_on_end;

  assign w_slot_end   = (r_slot_cnt == CW'(DIV - 1));
  assign w_slot_start = (r_slot_cnt == '0);
  // dim==7 stretches ON to the end of the slot so OFF never appears.
  assign w_on_len_nxt = (i_dim == 3'd7) ? CW'(DIV - BLANK)
                                        : CW'(ON_UNIT * (int'(i_dim) + 1));
  assign w_on_end     = CW'(BLANK - 1) + r_on_len;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot_cnt <= '0;
      r_sel      <= 1'b0;
      r_on_len   <= CW'(ON_UNIT);
    end else begin
      if (w_slot_start) r_on_len <= w_on_len_nxt;
      if (w_slot_end) begin
        r_slot_cnt <= '0;
        r_sel      <= ~r_sel;
      end else begin
        r_slot_cnt <= r_slot_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_phase <= PH_BLANK;
    else     r_phase <= w_phase_nxt;
  end

  always_comb begin
    w_phase_nxt = r_phase;
    if (w_slot_end) begin
      w_phase_nxt = PH_BLANK;
    end else begin
      case (r_phase)
        PH_BLANK: if (r_slot_cnt == CW'(BLANK - 1)) w_phase_nxt = PH_ON;
        PH_ON:    if (r_slot_cnt == w_on_end)       w_phase_nxt = PH_OFF;
        PH_OFF:   w_phase_nxt = PH_OFF;
        default:  w_phase_nxt = PH_BLANK;
      endcase
    end
  end

  always_comb begin
    o_phase      = r_phase;
    o_sel        = r_sel;
    o_boundary   = w_slot_end & r_sel;
    o_slot_start = w_slot_start;
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Two-digit multiplexed 7-segment pin driver with frame-synchronous double buffering.
// All pins registered (1-cycle latency); polarity applied only at the output register.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIV            = 50000,
  parameter int BLANK          = 500,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_lo,
  input  logic [6:0] seg_hi,
  input  logic       load,
  input  logic       lz_blank,
  input  logic [2:0] dim,
  output logic [6:0] seg_out,
  output logic [1:0] dig_en,
  output logic       frame_done
);

  localparam logic       SEG_INV  = (SEG_ACTIVE_LOW != 0);
  localparam logic       DIG_INV  = (DIG_ACTIVE_LOW != 0);
  localparam logic [6:0] SEG_IDLE = {7{SEG_INV}};
  localparam logic [1:0] DIG_IDLE = {2{DIG_INV}};

  phase_t     w_phase;
  digit_t     w_sel;
  logic       w_boundary;
  logic       w_slot_start;
  logic [6:0] w_seg_ah;
  logic [1:0] w_dig_ah;

  logic [6:0] r_shadow_lo, r_shadow_hi;
  logic [6:0] r_active_lo, r_active_hi;
  logic       r_pending;
  logic       r_lz;
  logic [6:0] r_seg_out;
  logic [1:0] r_dig_en;
  logic       r_frame_done;

  seg7_slot_timer #(
    .DIV   (DIV),
    .BLANK (BLANK)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .i_dim        (dim),
    .o_phase      (w_phase),
    .o_sel        (w_sel),
    .o_boundary   (w_boundary),
    .o_slot_start (w_slot_start)
  );

  // A load landing on the boundary skips the shadow and is shown next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow_lo <= SEG_OFF;
      r_shadow_hi <= SEG_OFF;
      r_active_lo <= SEG_OFF;
      r_active_hi <= SEG_OFF;
      r_pending   <= 1'b0;
      r_lz        <= 1'b0;
    end else begin
      if (w_slot_start) r_lz <= lz_blank;
      if (w_boundary) begin
        if (load) begin
          r_active_lo <= seg_lo;
          r_active_hi <= seg_hi;
        end else if (r_pending) begin
          r_active_lo <= r_shadow_lo;
          r_active_hi <= r_shadow_hi;
        end
        r_pending <= 1'b0;
      end else if (load) begin
        r_shadow_lo <= seg_lo;
        r_shadow_hi <= seg_hi;
        r_pending   <= 1'b1;
      end
    end
  end

  always_comb begin
    w_seg_ah = SEG_OFF;
    w_dig_ah = 2'b00;
    if (w_phase == PH_ON) begin
      if (w_sel) begin
        w_dig_ah = 2'b10;
        w_seg_ah = (r_lz && (r_active_hi == SEG_ZERO)) ? SEG_OFF : r_active_hi;
      end else begin
        w_dig_ah = 2'b01;
        w_seg_ah = r_active_lo;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg_out    <= SEG_IDLE;
      r_dig_en     <= DIG_IDLE;
      r_frame_done <= 1'b0;
    end else begin
      r_seg_out    <= w_seg_ah ^ SEG_IDLE;
      r_dig_en     <= w_dig_ah ^ DIG_IDLE;
      r_frame_done <= w_boundary;
    end
  end

  assign seg_out    = r_seg_out;
  assign dig_en     = r_dig_en;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver at DIV=16, BLANK=2, active-low pins.
module tb_seg7_scan_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg_lo, seg_hi;
  logic       load, lz_blank;
  logic [2:0] dim;
  logic [6:0] seg_out;
  logic [1:0] dig_en;
  logic       frame_done;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: position of the upcoming cycle within the frame.
  int         m_k = 0;
  bit         m_sel = 1'b0;
  logic [6:0] m_act_lo = '0, m_act_hi = '0;
  logic [6:0] m_sh_lo = '0, m_sh_hi = '0;
  bit         m_pend = 1'b0;
  logic [2:0] m_dim = 3'd0;
  bit         m_lz = 1'b0;
  logic [9:0] sb_q[$];

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .DIV            (16),
    .BLANK          (2),
    .SEG_ACTIVE_LOW (1),
    .DIG_ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_lo     (seg_lo),
    .seg_hi     (seg_hi),
    .load       (load),
    .lz_blank   (lz_blank),
    .dim        (dim),
    .seg_out    (seg_out),
    .dig_en     (dig_en),
    .frame_done (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic tick();
    logic [6:0] e_seg, pat;
    logic [1:0] e_dig;
    logic       e_fd;
    logic [9:0] e_v;
    int         len;
    bit         on;
    if (rst) begin
      e_seg = 7'h7F; e_dig = 2'b11; e_fd = 1'b0;
      m_k = 0; m_sel = 1'b0; m_act_lo = '0; m_act_hi = '0; m_pend = 1'b0;
    end else begin
      if (m_k == 0) begin m_dim = dim; m_lz = lz_blank; end
      len = (m_dim == 3'd7) ? 14 : int'(m_dim) + 1;
      on  = (m_k >= 2) && (m_k < 2 + len);
      pat = m_sel ? ((m_lz && m_act_hi == 7'b1111110) ? 7'b0 : m_act_hi) : m_act_lo;
      e_seg = on ? ~pat : 7'h7F;
      e_dig = on ? (m_sel ? 2'b01 : 2'b10) : 2'b11;
      e_fd  = (m_k == 15) && m_sel;
      if (m_k == 15 && m_sel) begin
        if (load) begin m_act_lo = seg_lo; m_act_hi = seg_hi; end
        else if (m_pend) begin m_act_lo = m_sh_lo; m_act_hi = m_sh_hi; end
        m_pend = 1'b0;
      end else if (load) begin
        m_sh_lo = seg_lo; m_sh_hi = seg_hi; m_pend = 1'b1;
      end
      if (m_k == 15) begin m_k = 0; m_sel = ~m_sel; end
      else m_k++;
    end
    sb_q.push_back({e_seg, e_dig, e_fd});
    @(posedge clk);
    #1;
    e_v = sb_q.pop_front();
    chk("seg_out", seg_out, e_v[9:3]);
    chk("dig_en", dig_en, e_v[2:1]);
    chk("frame_done", frame_done, e_v[0]);
    chk("dig_excl", dig_en == 2'b00, 0);
  endtask

  task automatic do_load(input logic [6:0] hi, input logic [6:0] lo);
    seg_hi = hi; seg_lo = lo; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_pos(input int k, input bit s);
    int n = 0;
    while (!(m_k == k && m_sel == s) && n < 64) begin
      tick();
      n++;
    end
    chk("wait_bound", n < 64, 1);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; seg_lo = '0; seg_hi = '0; dim = 3'd7; lz_blank = 1'b0;
    repeat (4) tick();
    rst = 1'b0;
    repeat (64) tick();

    do_load(7'b0110000, 7'b1101101);
    repeat (70) tick();

    dim = 3'd0;
    repeat (64) tick();
    wait_pos(5, 1'b0);
    dim = 3'd3;
    repeat (80) tick();

    dim = 3'd7;
    wait_pos(3, 1'b0);
    do_load(7'b1111001, 7'b0110011);
    repeat (5) tick();
    do_load(7'b1011011, 7'b1110000);
    repeat (70) tick();

    wait_pos(15, 1'b1);
    do_load(7'b1111111, 7'b1110111);
    repeat (40) tick();

    lz_blank = 1'b1;
    do_load(7'b1111110, 7'b0110000);
    repeat (70) tick();
    lz_blank = 1'b0;
    repeat (64) tick();

    wait_pos(1, 1'b0);
    do_load(7'b1101101, 7'b1111001);
    wait_pos(5, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (70) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed scan driver for the two-digit 7-segment display, downstream of the hex-to-7-segment decoder. It takes the decoder's two active-high segment patterns and double-buffers them so each frame shows one consistent value. It then scans the two digits on a shared segment bus with an anti-ghosting blank gap, 8-level brightness and optional leading-zero suppression. Its outputs drive the board's segment and digit-enable pins directly.

## Interface
- DIV, 50000: clock cycles per digit slot; minimum BLANK+8.
- BLANK, 500: blanking cycles at the start of each slot; minimum 1.
- SEG_ACTIVE_LOW, 1: 1 means segment pins are driven low to light.
- DIG_ACTIVE_LOW, 1: 1 means digit-enable pins are driven low to select.
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- seg_lo  in  7  low-digit pattern, active-high, bit6..bit0 = a..g.
- seg_hi  in  7  high-digit pattern, same encoding.
- load  in  1  one-cycle strobe; captures seg_lo/seg_hi into the shadow register.
- lz_blank  in  1  when 1, a high-digit pattern equal to SEG_ZERO (7'b1111110) is shown blank.
- dim  in  3  brightness; on-window is (dim+1)/8 of the drive window.
- seg_out  out  7  segment pins, polarity per SEG_ACTIVE_LOW.
- dig_en  out  2  digit enables; bit0 = low digit, bit1 = high digit; polarity per DIG_ACTIVE_LOW.
- frame_done  out  1  one-cycle pulse in the last cycle of the high-digit slot.

## Operation
- Internal state:
  - slot_cnt: 0..DIV-1.
  - sel: 0 = low digit, 1 = high digit.
  - shadow pair, active pair, and pending flag.
- load=1 writes the shadow pair and sets pending. A later load before the frame boundary overwrites the shadow (last value wins).
- Frame boundary is the cycle where slot_cnt==DIV-1 and sel==1. At the boundary, if pending, shadow is copied to active and pending is cleared.
- load asserted in the boundary cycle bypasses the shadow: its data goes straight to active and pending stays 0.
- Within a slot, the phase FSM runs:
  - BLANK: cycles 0..BLANK-1; all digits and segments off.
  - ON: cycles BLANK..BLANK+ON_LEN-1; selected digit enabled and its active pattern driven.
  - OFF: remaining cycles; all off.
- Brightness:
  - ON_UNIT = (DIV-BLANK)/8, integer division, computed as a localparam.
  - ON_LEN = ON_UNIT*(dim+1), except dim==7, which gives ON_LEN = DIV-BLANK so OFF is skipped.
  - dim is sampled at slot_cnt==0 and held for the whole slot.
- Slot end (slot_cnt==DIV-1): slot_cnt returns to 0, sel toggles, FSM returns to BLANK.
- Leading-zero blanking: with lz_blank=1 and the active high pattern equal to SEG_ZERO, the high-digit ON phase drives segments off but dig_en still follows timing. lz_blank is sampled at the same point as dim.
- The low digit is never suppressed.
- Polarity is applied only at the output register; all internal logic is active-high.

## Timing
- seg_out, dig_en and frame_done are registered.
- Pin state for slot cycle k appears on the clock edge after slot_cnt==k (1-cycle latency, constant).
- Outputs during reset and the cycle after release:
  - seg_out all off (7'h7F if SEG_ACTIVE_LOW, else 0).
  - dig_en all off.
  - frame_done=0.
- Reset values of internal state: slot_cnt=0, sel=0, FSM=BLANK, shadow=active=7'b0 (blank), pending=0.
- Mid-operation rst: outputs go off on the next edge and any pending load is discarded.
- After rst releases, the first displayed value is the first load whose transfer completes at a frame boundary.
- Load-to-display worst case: one frame (2*DIV cycles) plus BLANK plus 1.
- dig_en never has both bits active. At least BLANK cycles separate one digit's enable from the other's.
- frame_done frequency is clk/(2*DIV).

## Structure
- Package seg7_pkg holds:
  - SEG_ZERO = 7'b1111110 and SEG_OFF = 7'b0000000.
  - the phase enum {BLANK, ON, OFF}.
  - the digit index type (1 bit).
- Sub-module seg7_slot_timer (parameters DIV, BLANK) owns slot_cnt, sel, the phase FSM and the dim/ON_LEN computation. It outputs phase, sel, boundary and slot_start.
- The top level owns the shadow/active/pending registers, lz logic, polarity and output registers.

## Test plan
All scenarios use DIV=16, BLANK=2, both polarities active-low.
- Reset hold, then release with no load -> seg_out=7'h7F and dig_en=2'b11 for 64 cycles; frame_done pulses every 32 cycles.
- load with seg_hi=7'b0110000, seg_lo=7'b1101101, dim=7 -> from the next frame:
  - low slot: dig_en=2'b10 on cycles 2..15, seg_out=7'b0010010.
  - high slot: dig_en=2'b01, seg_out=7'b1001111.
- dim=0, then dim=3 -> ON lasts exactly 1 cycle, then 4 cycles, per slot. A dim change mid-slot takes effect only at the next slot.
- Two loads in one frame (values A then B) -> only B is ever displayed. A load in the boundary cycle is displayed in the immediately following frame.
- lz_blank=1 with seg_hi=SEG_ZERO -> high-slot seg_out=7'h7F while dig_en still cycles. With lz_blank=0 the same input gives seg_out=7'b0000001.
- rst asserted during an ON phase with a load pending -> outputs are off on the next edge. After release the display stays blank until a new load.
